// File: rtl/access_pkg.sv
// Shared definitions for the keypad entry transmitter and the access-control
// FSM that consumes its frames: key codes, frame geometry, state encoding.
package access_pkg;

    localparam logic [3:0] KEY_CHANGE = 4'hA;
    localparam logic [3:0] KEY_BKSP   = 4'hB;
    localparam logic [3:0] KEY_CLEAR  = 4'hC;
    localparam logic [3:0] KEY_ENTER  = 4'hE;

    localparam int ENTRY_DIGITS = 4;
    localparam int FRAME_W      = 17;
    localparam int WORD_W       = FRAME_W - 1;
    localparam int DCNT_W       = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SEND    = 2'd2
    } entry_state_e;

    // Codes 0x0..0x9 are BCD digits; everything above is a command or ignored.
    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/access_key_entry_tx_entry_timer.sv
// Loadable counter with a terminal-count compare. Counts down or up depending
// on COUNT_UP; 'expired' is high while the count equals 'term'.
// Clear has priority over load, load over count enable.
module entry_timer #(
    parameter int WIDTH    = 8,
    parameter bit COUNT_UP = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic [WIDTH-1:0] term,
    output logic             expired
);

    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] cnt_q;

    // Next count: clear, reload, or step in the configured direction.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            if (COUNT_UP) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Count register, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == term);

endmodule

// File: rtl/access_key_entry_tx.sv
// Keypad frame transmitter: collects up to four BCD digits (optionally
// preceded by CHANGE) and, on ENTER, presents {change_flag, digits} on
// data_out with data_load held high for LOAD_HOLD cycles.
// Optional feature macro: ENTRY_TIMEOUT_EN -- discards a partial entry after
// TIMEOUT_CYCLES idle cycles in COLLECT.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no entry in progress; digit or CHANGE starts one
// COLLECT | building the word; edit keys, ENTER sends when four digits held
// SEND    | frame on data_out, data_load high, keys not accepted
module access_key_entry_tx
    import access_pkg::*;
#(
    parameter int LOAD_HOLD      = 3,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_valid,
    input  logic [3:0]         key_code,
    output logic               key_ready,
    output logic [FRAME_W-1:0] data_out,
    output logic               data_load,
    output logic               entry_error,
    output logic [DCNT_W-1:0]  digit_count
);

    localparam int HOLD_W = (LOAD_HOLD > 1) ? $clog2(LOAD_HOLD) : 1;
    localparam logic [DCNT_W-1:0] FULL_CNT = DCNT_W'(ENTRY_DIGITS);

    if (LOAD_HOLD < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("access_key_entry_tx: LOAD_HOLD and TIMEOUT_CYCLES must be >= 1");
    end

    entry_state_e       state_q, state_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic               flag_q, flag_d;
    logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
    logic [FRAME_W-1:0] dout_q, dout_d;
    logic               load_q, load_d;
    logic               err_q, err_d;

    logic key_acc;
    logic hold_load;
    logic hold_expired;

    assign key_ready = (state_q != SEND);
    assign key_acc   = key_valid && key_ready;

    entry_timer #(
        .WIDTH    (HOLD_W),
        .COUNT_UP (1'b0)
    ) u_hold_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (1'b0),
        .load     (hold_load),
        .load_val (HOLD_W'(LOAD_HOLD - 1)),
        .en       ((state_q == SEND) && !hold_expired),
        .term     ('0),
        .expired  (hold_expired)
    );

`ifdef ENTRY_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic tmo_expired;

    // Idle-time counter: runs only in COLLECT and restarts on any accepted key,
    // so a key arriving on the expiry cycle always wins.
    entry_timer #(
        .WIDTH    (TMO_W),
        .COUNT_UP (1'b1)
    ) u_tmo_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      ((state_q != COLLECT) || key_acc || tmo_expired),
        .load     (1'b0),
        .load_val ('0),
        .en       (state_q == COLLECT),
        .term     (TMO_W'(TIMEOUT_CYCLES - 1)),
        .expired  (tmo_expired)
    );
`endif

    // Next-state and next-output decode for the entry FSM.
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        flag_d    = flag_q;
        dcnt_d    = dcnt_q;
        dout_d    = dout_q;
        load_d    = load_q;
        err_d     = 1'b0;
        hold_load = 1'b0;

        case (state_q)
            IDLE: begin
                if (key_acc) begin
                    if (is_digit(key_code)) begin
                        word_d  = {12'h000, key_code};
                        dcnt_d  = 3'd1;
                        state_d = COLLECT;
                    end else if (key_code == KEY_CHANGE) begin
                        flag_d  = 1'b1;
                        dcnt_d  = '0;
                        state_d = COLLECT;
                    end else if (key_code == KEY_ENTER) begin
                        err_d = 1'b1;
                    end
                end
            end

            COLLECT: begin
                if (key_acc) begin
                    if (is_digit(key_code)) begin
                        if (dcnt_q < FULL_CNT) begin
                            word_d = {word_q[11:0], key_code};
                            dcnt_d = dcnt_q + 3'd1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        case (key_code)
                            KEY_BKSP: begin
                                if (dcnt_q != '0) begin
                                    word_d = word_q >> 4;
                                    dcnt_d = dcnt_q - 3'd1;
                                end else begin
                                    flag_d  = 1'b0;
                                    state_d = IDLE;
                                end
                            end
                            KEY_CHANGE: begin
                                if (dcnt_q == '0) begin
                                    flag_d = 1'b1;
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                            KEY_CLEAR: begin
                                word_d  = '0;
                                flag_d  = 1'b0;
                                dcnt_d  = '0;
                                state_d = IDLE;
                            end
                            KEY_ENTER: begin
                                if (dcnt_q == FULL_CNT) begin
                                    dout_d    = {flag_q, word_q};
                                    load_d    = 1'b1;
                                    hold_load = 1'b1;
                                    state_d   = SEND;
                                end else begin
                                    err_d   = 1'b1;
                                    word_d  = '0;
                                    flag_d  = 1'b0;
                                    dcnt_d  = '0;
                                    state_d = IDLE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
`ifdef ENTRY_TIMEOUT_EN
                else if (tmo_expired) begin
                    err_d   = 1'b1;
                    word_d  = '0;
                    flag_d  = 1'b0;
                    dcnt_d  = '0;
                    state_d = IDLE;
                end
`endif
            end

            SEND: begin
                if (hold_expired) begin
                    load_d  = 1'b0;
                    word_d  = '0;
                    flag_d  = 1'b0;
                    dcnt_d  = '0;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // FSM state and registered outputs; reset wins even in the middle of SEND.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            flag_q  <= 1'b0;
            dcnt_q  <= '0;
            dout_q  <= '0;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            flag_q  <= flag_d;
            dcnt_q  <= dcnt_d;
            dout_q  <= dout_d;
            load_q  <= load_d;
            err_q   <= err_d;
        end
    end

    assign data_out    = dout_q;
    assign data_load   = load_q;
    assign entry_error = err_q;
    assign digit_count = dcnt_q;

endmodule

// File: tb/tb_access_key_entry_tx.sv
// Bench for access_key_entry_tx: directed key sequences followed by random
// key traffic, every cycle compared against a queue-based model of the entry.
module tb_access_key_entry_tx;

    localparam int LH  = 3;
    localparam int TMO = 8;
`ifdef ENTRY_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        key_ready;
    logic [16:0] data_out;
    logic        data_load;
    logic        entry_error;
    logic [2:0]  digit_count;

    int tests = 0;
    int fails = 0;

    // Reference model: the entry as a list of digits in entry order.
    logic [3:0]  q[$];
    bit          m_flag, m_active, m_load, m_err;
    logic [16:0] m_dout;
    int          m_send_left, m_idle;

    access_key_entry_tx #(
        .LOAD_HOLD      (LH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ready   (key_ready),
        .data_out    (data_out),
        .data_load   (data_load),
        .entry_error (entry_error),
        .digit_count (digit_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_clear();
        q.delete();
        m_flag   = 1'b0;
        m_active = 1'b0;
        m_idle   = 0;
    endfunction

    function automatic void apply_key(input logic [3:0] c);
        if (c <= 4'd9) begin
            if (!m_active) begin
                q.delete();
                q.push_back(c);
                m_active = 1'b1;
            end else if (q.size() < 4) begin
                q.push_back(c);
            end else begin
                m_err = 1'b1;
            end
        end else begin
            case (c)
                4'hA: begin
                    if (!m_active) begin
                        m_flag = 1'b1; m_active = 1'b1;
                    end else if (q.size() == 0) begin
                        m_flag = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                end
                4'hB: if (m_active) begin
                    if (q.size() > 0) void'(q.pop_back());
                    else m_clear();
                end
                4'hC: if (m_active) m_clear();
                4'hE: begin
                    if (!m_active) begin
                        m_err = 1'b1;
                    end else if (q.size() == 4) begin
                        m_dout      = {m_flag, q[0], q[1], q[2], q[3]};
                        m_load      = 1'b1;
                        m_send_left = LH;
                    end else begin
                        m_err = 1'b1;
                        m_clear();
                    end
                end
                default: ;
            endcase
        end
    endfunction

    function automatic void model_step(input logic r, input logic v, input logic [3:0] c);
        if (!r) begin
            m_clear();
            m_dout = '0; m_load = 1'b0; m_err = 1'b0; m_send_left = 0;
        end else begin
            m_err = 1'b0;
            if (m_send_left > 0) begin
                m_send_left--;
                if (m_send_left == 0) begin
                    m_load = 1'b0;
                    m_clear();
                end
            end else if (v) begin
                m_idle = 0;
                apply_key(c);
            end else if (TMO_EN && m_active) begin
                m_idle++;
                if (m_idle >= TMO) begin
                    m_err = 1'b1;
                    m_clear();
                end
            end
        end
    endfunction

    task automatic check_all();
        check("data_out",    32'(data_out),    32'(m_dout));
        check("data_load",   32'(data_load),   32'(m_load));
        check("entry_error", 32'(entry_error), 32'(m_err));
        check("digit_count", 32'(digit_count), 32'(q.size()));
        check("key_ready",   32'(key_ready),   32'(m_send_left == 0));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(rst, key_valid, key_code);
        #1;
        check_all();
    endtask

    task automatic press(input logic [3:0] c);
        key_valid = 1'b1;
        key_code  = c;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!key_ready && n < 20) begin
            tick();
            n++;
        end
        check("ready_timeout", 32'(key_ready), 32'd1);
    endtask

    initial begin
        int n_load, n_busy;
        logic [3:0] rc;

        m_clear();
        m_dout = '0; m_load = 1'b0; m_err = 1'b0; m_send_left = 0;

        // Reset state
        rst = 1'b0;
        idle(2);
        check("reset_dout", 32'(data_out), 32'h0);
        rst = 1'b1;
        idle(2);

        // 1,2,3,4,ENTER: three cycles of data_load and of key_ready low
        press(4'h1); press(4'h2); press(4'h3); press(4'h4);
        press(4'hE);
        n_load = data_load ? 1 : 0;
        n_busy = key_ready ? 0 : 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (data_load) n_load++;
            if (!key_ready) n_busy++;
        end
        check("frame1",      32'(data_out), 32'h01234);
        check("load_cycles", 32'(n_load),   32'd3);
        check("busy_cycles", 32'(n_busy),   32'd3);
        check("dcnt_after",  32'(digit_count), 32'd0);

        // CHANGE prefix
        press(4'hA); press(4'h9); press(4'h8); press(4'h7); press(4'h6);
        press(4'hE);
        wait_ready();
        check("frame_change", 32'(data_out), 32'h19876);

        // BACKSPACE inside an entry
        press(4'h5); press(4'h6); press(4'hB); press(4'h7); press(4'h8); press(4'h9);
        press(4'hE);
        wait_ready();
        check("frame_bksp", 32'(data_out), 32'h05789);

        // Short ENTER aborts, previous frame kept
        press(4'h1); press(4'h2); press(4'hE);
        check("short_err",  32'(entry_error), 32'd1);
        check("short_load", 32'(data_load),   32'd0);
        idle(2);
        check("frame_kept", 32'(data_out), 32'h05789);

        // Fifth digit rejected, four digits still sent
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
        check("fifth_err",  32'(entry_error), 32'd1);
        check("fifth_dcnt", 32'(digit_count), 32'd4);
        press(4'hE);
        wait_ready();
        check("frame_fifth", 32'(data_out), 32'h01234);

        // Reset during the second SEND cycle
        press(4'h4); press(4'h3); press(4'h2); press(4'h1); press(4'hE);
        tick();
        rst = 1'b0;
        tick();
        check("rst_send_load", 32'(data_load), 32'd0);
        check("rst_send_dout", 32'(data_out),  32'h0);
        rst = 1'b1;
        tick();
        press(4'hE);
        check("rst_fresh_err",  32'(entry_error), 32'd1);
        check("rst_fresh_load", 32'(data_load),   32'd0);

`ifdef ENTRY_TIMEOUT_EN
        // Idle timeout discards the partial entry
        press(4'h3);
        idle(TMO - 1);
        check("tmo_pre_err", 32'(entry_error), 32'd0);
        tick();
        check("tmo_err",  32'(entry_error), 32'd1);
        check("tmo_dcnt", 32'(digit_count), 32'd0);
        // Key on the expiry cycle wins
        press(4'h3);
        idle(TMO - 1);
        press(4'h4);
        check("tmo_key_err",  32'(entry_error), 32'd0);
        check("tmo_key_dcnt", 32'(digit_count), 32'd2);
        press(4'hC);
`else
        // Without the timeout a partial entry waits indefinitely
        press(4'h3);
        idle(3 * TMO);
        check("no_tmo_dcnt", 32'(digit_count), 32'd1);
        check("no_tmo_err",  32'(entry_error), 32'd0);
        press(4'hC);
`endif

        // Random key traffic, including keys offered during SEND
        for (int i = 0; i < 1500; i++) begin
            key_valid = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 9) < 6) begin
                rc = 4'($urandom_range(0, 9));
            end else begin
                rc = 4'($urandom_range(10, 15));
            end
            key_code = rc;
            tick();
        end
        key_valid = 1'b0;
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
